// File: rtl/fpu_window_buffer.sv
//------------------------------------------------------------------------------
// Module      : fpu_window_buffer
// Description : Sliding-window column buffer for the FPU convolution datapath.
//               Keeps the last KERNEL pixel columns (COL_WIDTH pixels each),
//               shifting in one column per accepted transfer, and presents a
//               window to the FPU array once KERNEL columns of the current
//               image row are resident. Valid/ready on both sides.
//
// Ports       : clk        - clock, all state updates on posedge
//               rst_n      - asynchronous, active-low reset
//               col_in     - incoming column, col_in[0] = top pixel
//               in_valid   - col_in/row_start valid this cycle
//               row_start  - col_in is the first column of a new image row
//               in_ready   - buffer accepts col_in this cycle
//               win        - window, win[0] = oldest, win[KERNEL-1] = newest
//               win_valid  - win holds a complete, unconsumed window
//               win_ready  - FPU consumes win this cycle
//               fill       - resident columns of the current row (sat. KERNEL)
//
// Build option: FPU_WINDOW_EDGE_REPLICATE_EN
//               When defined, the first column of a row is written into every
//               slot (left-edge replicate padding) and fill restarts at
//               KERNEL/2 + 1, so the first window is centred on column 0.
//
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------

`default_nettype none

module fpu_window_buffer #(
    parameter int DATA_W    = 8,
    parameter int COL_WIDTH = 10,
    parameter int KERNEL    = 3     // legal range 2..15
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic [COL_WIDTH-1:0][DATA_W-1:0]               col_in,
    input  logic                                           in_valid,
    input  logic                                           row_start,
    output logic                                           in_ready,
    output logic [KERNEL-1:0][COL_WIDTH-1:0][DATA_W-1:0]   win,
    output logic                                           win_valid,
    input  logic                                           win_ready,
    output logic [$clog2(KERNEL+1)-1:0]                    fill
);

    localparam int c_FILL_W = $clog2(KERNEL + 1);
    localparam logic [c_FILL_W-1:0] c_FILL_FULL = c_FILL_W'(KERNEL);

`ifdef FPU_WINDOW_EDGE_REPLICATE_EN
    // Replicating the edge column pre-loads the left half of the kernel, so
    // the row already counts as having its centre column resident.
    localparam logic [c_FILL_W-1:0] c_FILL_ROW_START = c_FILL_W'(KERNEL / 2 + 1);
    localparam logic                c_REPLICATE      = 1'b1;
`else
    localparam logic [c_FILL_W-1:0] c_FILL_ROW_START = c_FILL_W'(1);
    localparam logic                c_REPLICATE      = 1'b0;
`endif

    logic [KERNEL-1:0][COL_WIDTH-1:0][DATA_W-1:0] r_win;
    logic [c_FILL_W-1:0]                          r_fill;
    logic                                         r_win_valid;

    logic                w_accept;
    logic                w_replicate;
    logic [c_FILL_W-1:0] w_fill_next;
    logic                w_valid_next;

    // A window that the FPU has not taken yet must never be shifted away;
    // taking it in the same cycle frees the slot for the next column.
    assign in_ready    = !r_win_valid || win_ready;
    assign w_accept    = in_valid && in_ready;
    assign w_replicate = c_REPLICATE && row_start;

    always_comb begin
        w_fill_next = r_fill;
        if (w_accept) begin
            if (row_start) begin
                w_fill_next = c_FILL_ROW_START;
            end else if (r_fill == c_FILL_FULL) begin
                w_fill_next = c_FILL_FULL;
            end else begin
                w_fill_next = r_fill + 1'b1;
            end
        end
    end

    // With fill saturated, accept+consume keeps win_valid high: one window
    // per column at full throughput.
    assign w_valid_next = w_accept ? (w_fill_next == c_FILL_FULL)
                                   : (r_win_valid && !win_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win       <= '0;
            r_fill      <= '0;
            r_win_valid <= 1'b0;
        end else begin
            r_fill      <= w_fill_next;
            r_win_valid <= w_valid_next;
            if (w_accept) begin
                for (int k = 0; k < KERNEL - 1; k++) begin
                    r_win[k] <= w_replicate ? col_in : r_win[k+1];
                end
                r_win[KERNEL-1] <= col_in;
            end
        end
    end

    assign win       = r_win;
    assign win_valid = r_win_valid;
    assign fill      = r_fill;

endmodule

`default_nettype wire

// File: tb/tb_fpu_window_buffer.sv
`default_nettype none

module tb_fpu_window_buffer;

    localparam int DW = 8;
    localparam int CW = 10;
    localparam int K  = 3;
    localparam int FW = $clog2(K + 1);

    typedef logic [CW-1:0][DW-1:0]        col_t;
    typedef logic [K-1:0][CW-1:0][DW-1:0] win_t;

    logic             clk = 1'b0;
    logic             rst_n;
    col_t             col_in;
    logic             in_valid;
    logic             row_start;
    logic             in_ready;
    win_t             win;
    logic             win_valid;
    logic             win_ready;
    logic [FW-1:0]    fill;

    fpu_window_buffer #(
        .DATA_W    (DW),
        .COL_WIDTH (CW),
        .KERNEL    (K)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_in    (col_in),
        .in_valid  (in_valid),
        .row_start (row_start),
        .in_ready  (in_ready),
        .win       (win),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .fill      (fill)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: history of accepted columns, newest at the back;
    // the window is simply the last K entries.
    col_t hist[$];
    int   m_fill;
    bit   m_valid;
    bit   obs_rdy;
    bit   exp_rdy;

    function automatic col_t const_col(input logic [7:0] v);
        col_t c;
        for (int p = 0; p < CW; p++) c[p] = v;
        return c;
    endfunction

    function automatic col_t rand_col();
        col_t c;
        for (int p = 0; p < CW; p++) c[p] = DW'($urandom_range(0, 255));
        return c;
    endfunction

    function automatic win_t model_win();
        win_t w;
        for (int k = 0; k < K; k++) w[k] = hist[k];
        return w;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < K; k++) hist.push_back(const_col(8'h00));
        m_fill  = 0;
        m_valid = 1'b0;
    endtask

    task automatic model_update(input bit v, input bit rs, input col_t c, input bit wr);
        bit ready;
        ready = !m_valid || wr;
        if (v && ready) begin
            if (rs) begin
`ifdef FPU_WINDOW_EDGE_REPLICATE_EN
                for (int k = 0; k < K; k++) hist.push_back(c);
                m_fill = K / 2 + 1;
`else
                hist.push_back(c);
                m_fill = 1;
`endif
            end else begin
                hist.push_back(c);
                m_fill = (m_fill + 1 > K) ? K : m_fill + 1;
            end
            while (hist.size() > K) void'(hist.pop_front());
            m_valid = (m_fill == K);
        end else if (m_valid && wr) begin
            m_valid = 1'b0;
        end
    endtask

    // Drives one cycle starting 1 time unit after a posedge; records the
    // observed and expected in_ready, then advances to 1 unit past the edge.
    task automatic step(input bit v, input bit rs, input col_t c, input bit wr);
        in_valid  = v;
        row_start = rs;
        col_in    = c;
        win_ready = wr;
        #1;
        obs_rdy = in_ready;
        exp_rdy = !m_valid || wr;
        @(posedge clk);
        model_update(v, rs, c, wr);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        row_start = 1'b1;
        col_in    = rand_col();
        win_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        total++; if (win !== '0) begin bad++; $display("FAIL reset_win got=%h exp=0", win); end
        total++; if (fill !== '0) begin bad++; $display("FAIL reset_fill got=%0d exp=0", fill); end
        total++; if (win_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", win_valid); end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        col_t cols[4];
        win_t held;
        cols[0] = const_col(8'h11);
        cols[1] = const_col(8'h22);
        cols[2] = const_col(8'h33);
        cols[3] = const_col(8'h44);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, i == 0, cols[i], 1'b0);
            total++; if (fill !== FW'(m_fill)) begin bad++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, fill, m_fill); end
            total++; if (win_valid !== m_valid) begin bad++; $display("FAIL fill_valid i=%0d got=%b exp=%b", i, win_valid, m_valid); end
            total++; if (win !== model_win()) begin bad++; $display("FAIL fill_win i=%0d got=%h exp=%h", i, win, model_win()); end
`ifdef FPU_WINDOW_EDGE_REPLICATE_EN
            if (i == 0) begin
                total++; if (fill !== FW'(2) || win_valid !== 1'b0) begin bad++; $display("FAIL edge_first got fill=%0d valid=%b exp fill=2 valid=0", fill, win_valid); end
            end
            if (i == 1) begin
                held[0] = cols[0]; held[1] = cols[0]; held[2] = cols[1];
                total++; if (win !== held || win_valid !== 1'b1) begin bad++; $display("FAIL edge_win got=%h valid=%b exp=%h valid=1", win, win_valid, held); end
            end
`endif
        end
`ifndef FPU_WINDOW_EDGE_REPLICATE_EN
        held[0] = cols[0]; held[1] = cols[1]; held[2] = cols[2];
        total++; if (win !== held || win_valid !== 1'b1 || fill !== FW'(3)) begin
            bad++; $display("FAIL abc_window got=%h valid=%b fill=%0d exp=%h valid=1 fill=3", win, win_valid, fill, held);
        end
`endif
        held = win;
        step(1'b1, 1'b0, cols[3], 1'b0);
        total++; if (obs_rdy !== 1'b0) begin bad++; $display("FAIL hold_off_ready got=%b exp=0", obs_rdy); end
        total++; if (win !== held) begin bad++; $display("FAIL hold_off_win got=%h exp=%h", win, held); end
    endtask

    task automatic test_throughput();
        int cnt;
        int exp_cnt;
        cnt = 0;
`ifdef FPU_WINDOW_EDGE_REPLICATE_EN
        exp_cnt = 9;
`else
        exp_cnt = 8;
`endif
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, i == 1, const_col(8'(i)), 1'b1);
            total++; if (obs_rdy !== 1'b1) begin bad++; $display("FAIL tput_ready col=%0d got=%b exp=1", i, obs_rdy); end
            total++; if (win !== model_win() || win_valid !== m_valid) begin
                bad++; $display("FAIL tput_win col=%0d got=%h v=%b exp=%h v=%b", i, win, win_valid, model_win(), m_valid);
            end
            if (win_valid === 1'b1) begin
                cnt++;
                total++; if (win[K-1] !== const_col(8'(i))) begin bad++; $display("FAIL tput_newest col=%0d got=%h", i, win[K-1]); end
            end
        end
        total++; if (cnt != exp_cnt) begin bad++; $display("FAIL tput_count got=%0d exp=%0d", cnt, exp_cnt); end
    endtask

    task automatic test_row_change();
        col_t d, e, f;
        win_t exp_w;
        d = const_col(8'h44); e = const_col(8'h55); f = const_col(8'h66);
        step(1'b1, 1'b1, d, 1'b1);
        total++; if (fill !== FW'(m_fill) || win_valid !== m_valid) begin bad++; $display("FAIL row_d got fill=%0d v=%b exp fill=%0d v=%b", fill, win_valid, m_fill, m_valid); end
`ifndef FPU_WINDOW_EDGE_REPLICATE_EN
        total++; if (fill !== FW'(1) || win_valid !== 1'b0) begin bad++; $display("FAIL row_restart got fill=%0d v=%b exp fill=1 v=0", fill, win_valid); end
`endif
        step(1'b1, 1'b0, e, 1'b1);
        total++; if (fill !== FW'(m_fill) || win_valid !== m_valid) begin bad++; $display("FAIL row_e got fill=%0d v=%b exp fill=%0d v=%b", fill, win_valid, m_fill, m_valid); end
        step(1'b1, 1'b0, f, 1'b1);
        total++; if (win !== model_win() || win_valid !== m_valid) begin bad++; $display("FAIL row_f got=%h v=%b exp=%h v=%b", win, win_valid, model_win(), m_valid); end
`ifndef FPU_WINDOW_EDGE_REPLICATE_EN
        exp_w[0] = d; exp_w[1] = e; exp_w[2] = f;
        total++; if (win !== exp_w || win_valid !== 1'b1) begin bad++; $display("FAIL row_def got=%h v=%b exp=%h v=1", win, win_valid, exp_w); end
`endif
    endtask

    task automatic test_stall();
        win_t held;
        col_t g;
        held = win;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, rand_col(), 1'b0);
            total++; if (obs_rdy !== 1'b0) begin bad++; $display("FAIL stall_ready i=%0d got=%b exp=0", i, obs_rdy); end
            total++; if (win !== held || win_valid !== 1'b1) begin bad++; $display("FAIL stall_win i=%0d got=%h v=%b exp=%h v=1", i, win, win_valid, held); end
        end
        g = rand_col();
        step(1'b1, 1'b0, g, 1'b1);
        total++; if (obs_rdy !== 1'b1) begin bad++; $display("FAIL release_ready got=%b exp=1", obs_rdy); end
        total++; if (win[K-1] !== g || win_valid !== 1'b1) begin bad++; $display("FAIL release_newest got=%h v=%b exp=%h v=1", win[K-1], win_valid, g); end
        total++; if (win !== model_win()) begin bad++; $display("FAIL release_win got=%h exp=%h", win, model_win()); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                rst_n = 1'b0;
                #1;
                total++; if (win !== '0 || fill !== '0 || win_valid !== 1'b0) begin
                    bad++; $display("FAIL async_reset n=%0d win=%h fill=%0d v=%b exp all 0", n, win, fill, win_valid);
                end
                model_reset();
                in_valid = 1'b0;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end else begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, rand_col(), $urandom_range(0, 4) < 3);
                total++; if (obs_rdy !== exp_rdy) begin bad++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, obs_rdy, exp_rdy); end
                total++; if (win !== model_win()) begin bad++; $display("FAIL rnd_win n=%0d got=%h exp=%h", n, win, model_win()); end
                total++; if (fill !== FW'(m_fill)) begin bad++; $display("FAIL rnd_fill n=%0d got=%0d exp=%0d", n, fill, m_fill); end
                total++; if (win_valid !== m_valid) begin bad++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, win_valid, m_valid); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_throughput();
        test_row_change();
        test_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
